// File: rtl/div_unit.sv
// Iterative 32-bit integer divider (DIV/DIVU): radix-2 restoring, one quotient bit per cycle.
// Produces {remainder, quotient}; divide-by-zero returns zero after a short ZERO state.
`timescale 1ns/1ps
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               sign_i,
  input  logic               annul_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               busy_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o
);

  typedef enum logic [1:0] {StIdle, StZero, StBusy, StDone} state_e;

  localparam logic [5:0] LastCnt = 6'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [5:0]           cnt_q, cnt_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     div_q, div_d;
  logic                 neg_quo_q, neg_quo_d;
  logic                 neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0]   result_q, result_d;

  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       shifted, diff;
  logic                 ge;
  logic [WIDTH-1:0]     step_rem, step_quo;
  logic [WIDTH-1:0]     fin_rem, fin_quo;

  // Magnitudes fit in WIDTH bits even for the most negative value.
  assign a_mag = (sign_i && a_i[WIDTH-1]) ? -a_i : a_i;
  assign b_mag = (sign_i && b_i[WIDTH-1]) ? -b_i : b_i;

  // quo_q holds the remaining dividend bits and collects quotient bits from the right.
  assign shifted  = {rem_q, quo_q[WIDTH-1]};
  assign ge       = shifted >= {1'b0, div_q};
  assign diff     = shifted - {1'b0, div_q};
  assign step_rem = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign step_quo = {quo_q[WIDTH-2:0], ge};
  assign fin_quo  = neg_quo_q ? -step_quo : step_quo;
  assign fin_rem  = neg_rem_q ? -step_rem : step_rem;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    unique case (state_q)
      StIdle: begin
        if (start_i && !annul_i) begin
          if (b_i == '0) begin
            state_d = StZero;
          end else begin
            state_d   = StBusy;
            cnt_d     = '0;
            rem_d     = '0;
            quo_d     = a_mag;
            div_d     = b_mag;
            neg_quo_d = sign_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            neg_rem_d = sign_i & a_i[WIDTH-1];
          end
        end
      end
      StZero: begin
        if (annul_i) begin
          state_d = StIdle;
        end else begin
          state_d  = StDone;
          result_d = '0;
        end
      end
      StBusy: begin
        if (annul_i) begin
          state_d = StIdle;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == LastCnt) begin
            state_d  = StDone;
            result_d = {fin_rem, fin_quo};
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      div_q     <= div_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  // Gated by reset so a start held during reset never raises a stall.
  assign busy_o   = rst_ni & (((state_q == StIdle) & start_i & ~annul_i) |
                              (state_q == StZero) | (state_q == StBusy));
  assign ready_o  = (state_q == StDone);
  assign result_o = result_q;

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; only 32 is supported; HI/LO result is 2*WIDTH.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request a divide; sampled only in IDLE.
REQ-005 SHALL have port sign  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
REQ-006 SHALL have port annul  input  1  abort the operation in progress (pipeline flush).
REQ-007 SHALL have port a  input  32  dividend.
REQ-008 SHALL have port b  input  32  divisor.
REQ-009 SHALL have port busy  output  1  stall request to the datapath.
REQ-010 SHALL have port ready  output  1  one-cycle pulse; result valid.
REQ-011 SHALL have port result  output  64  {remainder (HI), quotient (LO)}.

Function
REQ-012 SHALL implement FSM states IDLE, ZERO, BUSY, DONE.
REQ-013 IDLE, start=1, b!=0 SHALL capture a, b, sign and go to BUSY.
REQ-014 IDLE, start=1, b==0 SHALL go to ZERO.
REQ-015 ZERO SHALL go to DONE after one cycle with the result register loaded to 64'h0.
REQ-016 BUSY SHALL run radix-2 restoring division on magnitudes, one quotient bit per cycle.
REQ-017 BUSY SHALL take exactly 32 cycles, counted by a 6-bit counter, then go to DONE.
REQ-018 Latency SHALL be: start sampled at edge N -> ready high during cycle N+33 (nonzero divisor) or N+2 (zero divisor).
REQ-019 DONE SHALL assert ready for exactly one cycle with result valid, then return to IDLE unconditionally.
REQ-020 Start during DONE SHALL be ignored; the datapath re-issues it after ready.
REQ-021 busy SHALL be combinational: 1 when (IDLE and start) or state is ZERO or BUSY; 0 in DONE and in IDLE without start.
REQ-022 Start while in ZERO, BUSY or DONE SHALL be ignored and SHALL NOT re-capture operands.
REQ-023 Signed mode SHALL divide |a| by |b|.
REQ-024 Signed mode SHALL negate the quotient when sign(a) != sign(b).
REQ-025 Signed mode SHALL give the remainder the sign of a.
REQ-026 Signed mode SHALL produce quotient 32'h80000000 and remainder 0 for a=32'h80000000, b=32'hFFFFFFFF, with no exception.
REQ-027 Unsigned mode SHALL treat a and b as 0..2^32-1.
REQ-028 The result register SHALL be written only at entry to DONE and SHALL hold its value through IDLE until the next completion.
REQ-029 annul=1 in ZERO or BUSY SHALL force IDLE on the next edge with no ready pulse and result unchanged.
REQ-030 annul in IDLE or DONE SHALL have no effect; DONE still pulses ready.
REQ-031 start=1 and annul=1 together in IDLE SHALL ignore start; the FSM stays in IDLE.
REQ-032 busy SHALL be 0 for annul in IDLE, including when start=1 in the same cycle.
REQ-033 Operands SHALL be registered at start; later changes on a/b/sign SHALL NOT affect the result.

Reset
REQ-034 rst low SHALL immediately force IDLE, counter 0, internal operand/partial-remainder registers 0, result 64'h0, ready 0, busy 0 (start ignored while rst low).
REQ-035 Reset mid-BUSY SHALL abort without a ready pulse; the first start after rst rises SHALL behave as from power-up.

Verification
REQ-036 Unsigned: start, sign=0, a=100, b=7 -> busy 1 for 33 cycles, ready at N+33, result={32'd2, 32'd14}.
REQ-037 Signed: a=-7 (32'hFFFFFFF9), b=2 -> result={32'hFFFFFFFF, 32'hFFFFFFFD} (rem -1, quo -3); a=7, b=-2 -> {32'd1, 32'hFFFFFFFD}.
REQ-038 Divide by zero: a=5, b=0, either sign -> ready at N+2, result 64'h0; then a=32'h80000000, b=-1 signed -> {32'h0, 32'h80000000}.
REQ-039 Annul at cycle N+10 of BUSY -> IDLE at N+11, no ready, busy 0, result retains previous value; new start then completes normally.
REQ-040 Unsigned a=32'hFFFFFFFF, b=1 -> {0, 32'hFFFFFFFF}; a/b changed during BUSY and start pulsed mid-operation -> result unaffected.
REQ-041 rst asserted asynchronously mid-BUSY (between edges) -> outputs 0 immediately, no ready after release.
